// File: rtl/display_pkg.sv
// Shared display timing defaults, raster helpers and color types for the scanout path.
package display_pkg;
  localparam int RES_X_DEF      = 400;
  localparam int RES_Y_DEF      = 300;
  localparam int PAL_LEN_DEF    = 256;
  localparam int COLOR_BITS_DEF = 12;
  localparam int H_FRONT_DEF    = 20;
  localparam int H_SYNC_DEF     = 64;
  localparam int H_BACK_DEF     = 44;
  localparam int V_FRONT_DEF    = 1;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BACK_DEF     = 11;

  typedef logic [COLOR_BITS_DEF-1:0] color_t;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic fs;
  } sync_t;

  // Bar 0 is leftmost: white, yellow, cyan, green, magenta, red, blue, black.
  localparam color_t [7:0] BAR_COLORS = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                         12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};

  function automatic int h_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  function automatic int v_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction
endpackage

// File: rtl/scanout_timing.sv
// Raster h/v counters with stage-0 decode of visible, syncs, vblank and frame start.
module scanout_timing
  import display_pkg::*;
#(
  parameter int RESOLUTION_X = RES_X_DEF,
  parameter int RESOLUTION_Y = RES_Y_DEF,
  parameter int H_FRONT      = H_FRONT_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BACK       = H_BACK_DEF,
  parameter int V_FRONT      = V_FRONT_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BACK       = V_BACK_DEF,
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          visible_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          vblank_o,
  output logic          frame_start_o
);
  localparam int H_TOTAL = h_total(RESOLUTION_X, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(RESOLUTION_Y, V_FRONT, V_SYNC, V_BACK);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(RESOLUTION_X);
  localparam logic [HW-1:0] HS_BEG = HW'(RESOLUTION_X + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(RESOLUTION_X + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(RESOLUTION_Y);
  localparam logic [VW-1:0] VS_BEG = VW'(RESOLUTION_Y + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(RESOLUTION_Y + V_FRONT + V_SYNC);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_run;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Decode is gated by reset so every stage-0 output reads 0 while reset is held.
  assign w_run         = ~reset_i;
  assign visible_o     = w_run & (r_h < H_VIS) & (r_v < V_VIS);
  assign hsync_o       = w_run & (r_h >= HS_BEG) & (r_h < HS_END);
  assign vsync_o       = w_run & (r_v >= VS_BEG) & (r_v < VS_END);
  assign vblank_o      = w_run & (r_v >= V_VIS);
  assign frame_start_o = w_run & (r_h == '0) & (r_v == '0);
  assign x_o           = visible_o ? r_h[XW-1:0] : '0;
  assign y_o           = visible_o ? r_v[YW-1:0] : '0;
endmodule

// File: rtl/scanout_engine.sv
// Raster scanout: framebuffer index fetch, palette lookup, 2-clock aligned video outputs.
// Optional color-bar generator enabled by defining SCANOUT_TEST_PATTERN_EN.
module scanout_engine
  import display_pkg::*;
#(
  parameter int RESOLUTION_X   = RES_X_DEF,
  parameter int RESOLUTION_Y   = RES_Y_DEF,
  parameter int PALETTE_LENGTH = PAL_LEN_DEF,
  parameter int COLOR_BITS     = COLOR_BITS_DEF,
  parameter int H_FRONT        = H_FRONT_DEF,
  parameter int H_SYNC         = H_SYNC_DEF,
  parameter int H_BACK         = H_BACK_DEF,
  parameter int V_FRONT        = V_FRONT_DEF,
  parameter int V_SYNC         = V_SYNC_DEF,
  parameter int V_BACK         = V_BACK_DEF
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  output logic [$clog2(RESOLUTION_X)-1:0]   fb_rd_x_o,
  output logic [$clog2(RESOLUTION_Y)-1:0]   fb_rd_y_o,
  output logic                              fb_rd_en_o,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] fb_rd_index_i,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] palette_wr_index_i,
  input  logic [COLOR_BITS-1:0]             palette_wr_color_i,
  input  logic                              palette_wr_en_i,
  input  logic                              test_pattern_i,
  output logic [COLOR_BITS-1:0]             color_o,
  output logic                              hsync_o,
  output logic                              vsync_o,
  output logic                              de_o,
  output logic                              vblank_o,
  output logic                              frame_start_o
);
  sync_t                   w_s0, r_s1, r_s2;
  logic [COLOR_BITS-1:0]   r_pal [PALETTE_LENGTH];
  logic [COLOR_BITS-1:0]   r_color;

  scanout_timing #(
    .RESOLUTION_X(RESOLUTION_X), .RESOLUTION_Y(RESOLUTION_Y),
    .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .x_o           (fb_rd_x_o),
    .y_o           (fb_rd_y_o),
    .visible_o     (w_s0.de),
    .hsync_o       (w_s0.hsync),
    .vsync_o       (w_s0.vsync),
    .vblank_o      (vblank_o),
    .frame_start_o (w_s0.fs)
  );

  assign fb_rd_en_o = w_s0.de;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_s0;
      r_s2 <= r_s1;
    end
  end

  // Palette is not reset: contents survive a raster reset.
  always_ff @(posedge clk_i) begin
    if (palette_wr_en_i) r_pal[palette_wr_index_i] <= palette_wr_color_i;
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  logic [$clog2(RESOLUTION_X)-1:0] r_x1;
  logic [2:0]                      w_bar;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_x1 <= '0;
    else         r_x1 <= fb_rd_x_o;
  end

  assign w_bar = 3'((int'(r_x1) * 8) / RESOLUTION_X);
`else
  logic w_unused_tp;
  assign w_unused_tp = test_pattern_i;
`endif

  // The palette read register doubles as the color output register; it reads
  // before the same-edge write lands, giving read-first behaviour.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)        r_color <= '0;
    else if (!r_s1.de)  r_color <= '0;
`ifdef SCANOUT_TEST_PATTERN_EN
    else if (test_pattern_i) r_color <= COLOR_BITS'(BAR_COLORS[w_bar]);
`endif
    else                r_color <= r_pal[fb_rd_index_i];
  end

  assign color_o       = r_color;
  assign de_o          = r_s2.de;
  assign hsync_o       = r_s2.hsync;
  assign vsync_o       = r_s2.vsync;
  assign frame_start_o = r_s2.fs;
endmodule

// File: doc/scanout_engine.md
# scanout_engine

Consumer stage downstream of the display processor. Generates raster timing for the framebuffer resolution, reads palette indices from the framebuffer read port, and translates them through an internal color palette that the display processor writes. Drives registered color, sync and data-enable outputs to the video encoder.

## Interface
- RESOLUTION_X, 400, visible pixels per line
- RESOLUTION_Y, 300, visible lines per frame
- PALETTE_LENGTH, 256, palette entries
- COLOR_BITS, 12, color word width (4:4:4 RGB)
- H_FRONT / H_SYNC / H_BACK, 20 / 64 / 44, horizontal porch and sync widths in clocks
- V_FRONT / V_SYNC / V_BACK, 1 / 2 / 11, vertical porch and sync widths in lines
- clk_i  in  1  pixel clock; the only clock
- reset_i  in  1  reset, asynchronous, active-high
- fb_rd_x_o  out  $clog2(RESOLUTION_X)  framebuffer read column
- fb_rd_y_o  out  $clog2(RESOLUTION_Y)  framebuffer read row
- fb_rd_en_o  out  1  framebuffer read strobe
- fb_rd_index_i  in  $clog2(PALETTE_LENGTH)  index returned one clock after fb_rd_en_o
- palette_wr_index_i  in  $clog2(PALETTE_LENGTH)  palette write address
- palette_wr_color_i  in  COLOR_BITS  palette write data
- palette_wr_en_i  in  1  palette write strobe
- test_pattern_i  in  1  select color-bar pattern (used only with SCANOUT_TEST_PATTERN_EN)
- color_o  out  COLOR_BITS  pixel color
- hsync_o, vsync_o  out  1  syncs, active-high
- de_o  out  1  data enable, high on visible pixels
- vblank_o  out  1  high while raster line ≥ RESOLUTION_Y (unaligned, stage 0)
- frame_start_o  out  1  one-clock pulse aligned with first visible pixel of each frame

## Operation
- H_TOTAL = RESOLUTION_X+H_FRONT+H_SYNC+H_BACK (528); V_TOTAL = RESOLUTION_Y+V_FRONT+V_SYNC+V_BACK (314).
- Stage 0: h counter 0..H_TOTAL-1, wraps to 0 and increments v; v counter 0..V_TOTAL-1, wraps to 0. Visible when h<RESOLUTION_X and v<RESOLUTION_Y. hsync when RESOLUTION_X+H_FRONT ≤ h < RESOLUTION_X+H_FRONT+H_SYNC; vsync analogous on v.
- fb_rd_x_o/fb_rd_y_o = h/v truncated when visible, 0 otherwise; fb_rd_en_o = visible. Both combinational from stage-0 counters.
- Stage 1: fb_rd_index_i valid; palette read issued with that index.
- Stage 2: palette data registered into color_o; color_o = 0 when aligned de is low.
- hsync, vsync, de, frame_start pass through a 2-deep delay line so all outputs align with color_o.
- Palette: PALETTE_LENGTH × COLOR_BITS RAM, synchronous write, synchronous read-first. Write and read of same index in same clock returns old data; new data visible from next read.
- Palette contents are not cleared by reset; initial contents at configuration are all zero.
- Raster never stalls; no backpressure on any port.

## Timing
- Reset (any time, including mid-line): h=v=0 immediately; all outputs and delay-line registers 0 (color_o=0, syncs/de/frame_start/vblank/fb_rd_en_o low; fb_rd_en_o rises at first clock after deassert since h=v=0 is visible).
- Latency: stage-0 pixel (h,v) appears on color_o/de_o exactly 2 clocks after fb_rd_en_o for that pixel.
- First frame after reset: de_o first high 2 clocks after reset release; frame_start_o high in that same clock.
- Line period H_TOTAL clocks; frame period H_TOTAL×V_TOTAL clocks (165,792 default).
- Last pixel wrap: h=H_TOTAL-1, v=V_TOTAL-1 → next h=0, v=0, frame_start asserted on stage 0.

## Configuration
- SCANOUT_TEST_PATTERN_EN defined: when test_pattern_i=1, stage 2 replaces palette data with 8 vertical bars, bar = h[stage-aligned] × 8 / RESOLUTION_X, colors {FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000}; framebuffer still read. test_pattern_i sampled per pixel.
- Not defined: test_pattern_i ignored; no bar logic synthesized.

## Structure
- Shared package display_pkg: default timing constants, H_TOTAL/V_TOTAL functions, color_t typedef (COLOR_BITS RGB), test-bar color constants.
- One sub-module: scanout_timing (h/v counters, sync/visible/vblank/frame_start decode). Palette RAM and alignment pipeline stay in scanout_engine.

## Test plan
- Reset release, run 2 frames → hsync period 528, width 64; vsync width 2×528 clocks; de_o high 400 clocks × 300 lines per frame.
- Framebuffer model returns index = x[7:0]; palette[i]=i → color_o at pixel x equals x[7:0] zero-extended, 2 clocks after fb_rd_en_o.
- Write palette[5]=ABC while reading index 5 same clock → that pixel shows old value, next pixel with index 5 shows ABC.
- Assert reset_i mid-line at h=200, v=100 → all outputs 0 asynchronously; after release counting restarts at (0,0), frame_start_o 2 clocks later.
- Blanking: at h=400..527 → de_o=0, color_o=000, fb_rd_en_o=0 despite nonzero fb_rd_index_i.
- With SCANOUT_TEST_PATTERN_EN, test_pattern_i=1 → x=0 gives FFF, x=399 gives 000; without macro → palette colors unchanged.
